// File: rtl/pu_or1k_pic_vec.sv
// pu_or1k_pic_vec: parametrised OR1K PIC with run-time level/edge trigger per line on SPR group 9.
// Define PU_OR1K_PIC_SYNC_EN to insert a 2-flop synchroniser on every irq_i bit.
module pu_or1k_pic_vec #(
  parameter int NUM_IRQ = 32,
  parameter int NMI_WIDTH = 0,
  parameter logic [31:0] TR_RESET = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_o,
  output logic [4:0]         irq_id_o,
  input  logic               irq_ack_i,
  output logic [31:0]        spr_picmr_o,
  output logic [31:0]        spr_picsr_o,
  input  logic               spr_access_i,
  input  logic               spr_we_i,
  input  logic [15:0]        spr_addr_i,
  input  logic [31:0]        spr_dat_i,
  output logic               spr_bus_ack,
  output logic [31:0]        spr_dat_o
);
  localparam logic [NUM_IRQ-1:0] NMI = NUM_IRQ'((64'd1 << NMI_WIDTH) - 64'd1);
  logic [NUM_IRQ-1:0] irq_s, irq_prev, picmr, pictr, edge_sr, edge_nxt, picsr, req;
  logic [NUM_IRQ-1:0] set_vec, clr_vec, chg_vec, ack_vec, dat;
  logic [4:0] id_nxt;
  logic wr, wr_mr, wr_sr, wr_tr;
  logic unused;
`ifdef PU_OR1K_PIC_SYNC_EN
  logic [NUM_IRQ-1:0] sync0, sync1;
  always_ff @(posedge clk)
    if (rst) {sync1, sync0} <= '0;
    else {sync1, sync0} <= {sync0, irq_i};
  assign irq_s = sync1;
`else
  assign irq_s = irq_i;
`endif
  assign unused = ^{spr_addr_i[15:11], spr_dat_i};
  assign dat = spr_dat_i[NUM_IRQ-1:0];
  assign wr = spr_access_i & spr_we_i;
  assign wr_mr = wr & (spr_addr_i[10:0] == 11'd0);
  assign wr_sr = wr & (spr_addr_i[10:0] == 11'd2);
  assign wr_tr = wr & (spr_addr_i[10:0] == 11'd3);
  // Edge lines report their flop; level lines follow the masked input directly.
  assign picsr = (pictr & edge_sr) | (~pictr & irq_s & picmr);
  assign req = picsr & picmr;
  assign set_vec = pictr & irq_s & ~irq_prev & picmr;
  assign ack_vec = (irq_ack_i && irq_o) ? NUM_IRQ'(1) << irq_id_o : '0;
  assign clr_vec = (wr_sr ? dat : '0) | ack_vec;
  assign chg_vec = wr_tr ? (pictr ^ dat) : '0;
  assign edge_nxt = ((edge_sr & ~clr_vec) | set_vec) & ~chg_vec;
  always_comb begin
    id_nxt = irq_id_o;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (req[i]) id_nxt = 5'(i);
  end
  always_ff @(posedge clk)
    if (rst) begin
      picmr <= NMI;
      pictr <= TR_RESET[NUM_IRQ-1:0];
      edge_sr <= '0;
      irq_prev <= '0;
      irq_o <= 1'b0;
      irq_id_o <= '0;
    end else begin
      if (wr_mr) picmr <= dat | NMI;
      if (wr_tr) pictr <= dat;
      edge_sr <= edge_nxt;
      irq_prev <= irq_s;
      irq_o <= |req;
      irq_id_o <= id_nxt;
    end
  assign spr_picmr_o = 32'(picmr);
  assign spr_picsr_o = 32'(picsr);
  assign spr_bus_ack = spr_access_i;
  always_comb
    spr_dat_o = !spr_access_i ? 32'h0 :
                spr_addr_i[10:0] == 11'd0 ? 32'(picmr) :
                spr_addr_i[10:0] == 11'd2 ? 32'(picsr) :
                spr_addr_i[10:0] == 11'd3 ? 32'(pictr) : 32'h0;
endmodule

// File: tb/tb_pu_or1k_pic_vec.sv
// tb_pu_or1k_pic_vec: directed checks of PIC mask/status/trigger registers and arbitration.
module tb_pu_or1k_pic_vec;
  localparam logic [15:0] MR = 16'h4800, SR = 16'h4802, TR = 16'h4803;
  logic clk = 0, rst = 1, irq_o, irq_ack_i = 0, spr_access_i = 0, spr_we_i = 0, spr_bus_ack;
  logic [31:0] irq_i = 0, spr_picmr_o, spr_picsr_o, spr_dat_i = 0, spr_dat_o, rd;
  logic [4:0] irq_id_o;
  logic [15:0] spr_addr_i = 0;
  int n_chk = 0, n_pass = 0;

  pu_or1k_pic_vec #(.NUM_IRQ(32), .NMI_WIDTH(2), .TR_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .irq_i(irq_i), .irq_o(irq_o), .irq_id_o(irq_id_o),
    .irq_ack_i(irq_ack_i), .spr_picmr_o(spr_picmr_o), .spr_picsr_o(spr_picsr_o),
    .spr_access_i(spr_access_i), .spr_we_i(spr_we_i), .spr_addr_i(spr_addr_i),
    .spr_dat_i(spr_dat_i), .spr_bus_ack(spr_bus_ack), .spr_dat_o(spr_dat_o));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spr_rd(input logic [15:0] a, output logic [31:0] d);
    spr_access_i = 1; spr_we_i = 0; spr_addr_i = a;
    #1;
    d = spr_dat_o;
    spr_access_i = 0;
  endtask

  task automatic spr_wr(input logic [15:0] a, input logic [31:0] d);
    spr_access_i = 1; spr_we_i = 1; spr_addr_i = a; spr_dat_i = d;
    step();
    spr_access_i = 0; spr_we_i = 0;
  endtask

  task automatic ack();
    irq_ack_i = 1;
    step();
    irq_ack_i = 0;
  endtask

  initial begin
    step(); step();
    rst = 0;
    // reset state
    spr_rd(MR, rd); chk("rst_picmr", rd, 32'h3);
    spr_rd(TR, rd); chk("rst_pictr", rd, 32'h0);
    spr_rd(SR, rd); chk("rst_picsr", rd, 32'h0);
    chk("rst_irq_o", 32'(irq_o), 32'h0);
    chk("rst_id", 32'(irq_id_o), 32'h0);
    spr_access_i = 1; spr_addr_i = 16'h4801;
    #1 chk("bus_ack", 32'(spr_bus_ack), 32'h1);
    chk("unmapped", spr_dat_o, 32'h0);
    spr_access_i = 0;
    #1 chk("no_access", spr_dat_o, 32'h0);
    spr_wr(MR, 32'h0);
    spr_rd(MR, rd); chk("nmi_keep", rd, 32'h3);
    // level lines 4 and 5
    spr_wr(MR, 32'h30);
    irq_i = 32'h30;
    spr_rd(SR, rd); chk("lvl_picsr", rd, 32'h30);
    chk("lvl_irq_pre", 32'(irq_o), 32'h0);
    step();
    chk("lvl_irq", 32'(irq_o), 32'h1);
    chk("lvl_id4", 32'(irq_id_o), 32'd4);
    irq_i = 32'h20;
    step();
    chk("lvl_id5", 32'(irq_id_o), 32'd5);
    irq_i = 0;
    step();
    chk("lvl_off", 32'(irq_o), 32'h0);
    chk("lvl_hold_id", 32'(irq_id_o), 32'd5);
    // edge line 8 with ack
    spr_wr(TR, 32'h100);
    spr_wr(MR, 32'h100);
    spr_rd(MR, rd); chk("mr_100", rd, 32'h103);
    irq_i = 32'h100;
    step();
    irq_i = 0;
    chk("edge_picsr", spr_picsr_o, 32'h100);
    chk("edge_lat1", 32'(irq_o), 32'h0);
    step();
    chk("edge_irq", 32'(irq_o), 32'h1);
    chk("edge_id8", 32'(irq_id_o), 32'd8);
    chk("edge_held", spr_picsr_o, 32'h100);
    ack();
    chk("ack_picsr", spr_picsr_o, 32'h0);
    chk("ack_irq_lag", 32'(irq_o), 32'h1);
    step();
    chk("ack_irq_off", 32'(irq_o), 32'h0);
    // collision: new edge beats software clear
    spr_wr(TR, 32'h300);
    spr_wr(MR, 32'h300);
    irq_i = 32'h200;
    step();
    irq_i = 0;
    step();
    chk("col_pend", spr_picsr_o, 32'h200);
    irq_i = 32'h200;
    spr_wr(SR, 32'h200);
    spr_rd(SR, rd); chk("col_keep", rd, 32'h200);
    irq_i = 0;
    spr_wr(SR, 32'h200);
    chk("sw_clear", spr_picsr_o, 32'h0);
    step(); step();
    chk("col_idle", 32'(irq_o), 32'h0);
    // priority between edge lines 3 and 7
    spr_wr(TR, 32'h88);
    spr_wr(MR, 32'h88);
    irq_i = 32'h88;
    step();
    irq_i = 0;
    step();
    chk("pri_irq", 32'(irq_o), 32'h1);
    chk("pri_id3", 32'(irq_id_o), 32'd3);
    ack();
    step();
    chk("pri_id7", 32'(irq_id_o), 32'd7);
    chk("pri_irq7", 32'(irq_o), 32'h1);
    ack();
    step();
    chk("pri_done", 32'(irq_o), 32'h0);
    chk("pri_picsr", spr_picsr_o, 32'h0);
    // masking keeps a pending edge; mode change clears it
    spr_wr(TR, 32'h40);
    spr_wr(MR, 32'h40);
    irq_i = 32'h40;
    step();
    irq_i = 0;
    step();
    chk("mode_id6", 32'(irq_id_o), 32'd6);
    spr_wr(MR, 32'h0);
    chk("mask_keep", spr_picsr_o, 32'h40);
    step();
    chk("mask_irq", 32'(irq_o), 32'h0);
    spr_wr(MR, 32'h40);
    step();
    chk("unmask_irq", 32'(irq_o), 32'h1);
    spr_wr(TR, 32'h0);
    chk("mode_clr", spr_picsr_o, 32'h0);
    step();
    chk("mode_irq", 32'(irq_o), 32'h0);
    // reset mid-operation
    spr_wr(MR, 32'hf0);
    irq_i = 32'h10;
    step();
    chk("pre_rst_irq", 32'(irq_o), 32'h1);
    spr_wr(TR, 32'h5);
    rst = 1; irq_i = 0;
    step();
    rst = 0;
    chk("mid_rst_irq", 32'(irq_o), 32'h0);
    chk("mid_rst_mr", spr_picmr_o, 32'h3);
    spr_rd(TR, rd); chk("mid_rst_tr", rd, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
